// File: rtl/uart_apb_master.sv
// APB3 initiator for the UART register map.
// A valid/ready command becomes one APB3 transfer, and the result is returned
// on a valid/ready response channel. Only one transfer is in flight at a time.
// A wait-state timeout aborts the transfer if the slave never raises PREADY.
module uart_apb_master #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      i_apb_pclk,
  input  logic                      i_apb_preset,
  // command channel
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] i_cmd_wdata,
  // response channel
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic                      o_rsp_timeout,
  // APB3 initiator interface
  output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
  output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
  output logic                      o_apb_pwrite,
  output logic                      o_apb_psel,
  output logic                      o_apb_penable,
  input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
  input  logic                      i_apb_pready,
  input  logic                      i_apb_pslverr
);

  // A zero timeout still needs a 1-bit counter so that the logic stays legal.
  localparam int unsigned CNT_W       = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TO_EN       = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TO_LAST_INT = (TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_INT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                    state_q,   state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q,   paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
  logic                      pwrite_q,  pwrite_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic                      err_q,     err_d;
  logic                      timeout_q, timeout_d;
  logic [CNT_W-1:0]          cnt_q,     cnt_d;

  // State and datapath registers; reset abandons any transfer without a response.
  always_ff @(posedge i_apb_pclk or posedge i_apb_preset) begin
    if (i_apb_preset) begin
      state_q   <= S_IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic and state-decoded handshake/APB control outputs.
  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    timeout_d     = timeout_q;
    cnt_d         = cnt_q;
    o_cmd_ready   = 1'b0;
    o_rsp_valid   = 1'b0;
    o_apb_psel    = 1'b0;
    o_apb_penable = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          paddr_d  = i_cmd_addr;
          pwdata_d = i_cmd_wdata;
          pwrite_d = i_cmd_write;
          cnt_d    = '0;
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        o_apb_psel = 1'b1;
        state_d    = S_ACCESS;
      end

      S_ACCESS: begin
        o_apb_psel    = 1'b1;
        o_apb_penable = 1'b1;
        if (i_apb_pready) begin
          // PREADY wins over a timeout landing in the same cycle.
          rdata_d   = pwrite_q ? '0 : i_apb_prdata;
          err_d     = i_apb_pslverr;
          timeout_d = 1'b0;
          state_d   = S_RESP;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (TO_EN && (cnt_q == TO_LAST)) begin
            rdata_d   = '0;
            err_d     = 1'b1;
            timeout_d = 1'b1;
            state_d   = S_RESP;
          end
        end
      end

      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_apb_paddr   = paddr_q;
  assign o_apb_pwdata  = pwdata_q;
  assign o_apb_pwrite  = pwrite_q;
  assign o_rsp_rdata   = rdata_q;
  assign o_rsp_err     = err_q;
  assign o_rsp_timeout = timeout_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// Self-checking bench for uart_apb_master, built with a short timeout.
// The bench acts as the APB slave and predicts each response from the transfer rules.
module tb_uart_apb_master;

  localparam int unsigned TOUT = 4;

  logic        clk;
  logic        preset;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdWrite;
  logic [31:0] cmdAddr;
  logic [31:0] cmdWdata;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic        rspTimeout;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int errCount   = 0;
  int checkCount = 0;

  uart_apb_master #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .i_apb_pclk   (clk),
    .i_apb_preset (preset),
    .i_cmd_valid  (cmdValid),
    .o_cmd_ready  (cmdReady),
    .i_cmd_write  (cmdWrite),
    .i_cmd_addr   (cmdAddr),
    .i_cmd_wdata  (cmdWdata),
    .o_rsp_valid  (rspValid),
    .i_rsp_ready  (rspReady),
    .o_rsp_rdata  (rspRdata),
    .o_rsp_err    (rspErr),
    .o_rsp_timeout(rspTimeout),
    .o_apb_paddr  (paddr),
    .o_apb_pwdata (pwdata),
    .o_apb_pwrite (pwrite),
    .o_apb_psel   (psel),
    .o_apb_penable(penable),
    .i_apb_prdata (prdata),
    .i_apb_pready (pready),
    .i_apb_pslverr(pslverr)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run gets stuck somewhere.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, observed, expected);
    end
  endtask

  // One complete command/APB/response exchange; waits = ACCESS cycles before PREADY.
  task automatic applyStimulus(input bit write, input logic [31:0] addr, input logic [31:0] wdata,
                               input int waits, input bit slverr, input logic [31:0] rdVal,
                               input int rspDelay);
    bit          expTimeout;
    int          expAccess;
    bit          expErr;
    logic [31:0] expRdata;
    int          k;

    // Reference outcome: the slave answers after waits+1 ACCESS cycles unless the
    // timeout budget of TOUT cycles runs out first.
    expTimeout = (waits >= int'(TOUT));
    expAccess  = expTimeout ? int'(TOUT) : waits + 1;
    expErr     = expTimeout || slverr;
    expRdata   = (expTimeout || write) ? 32'h0 : rdVal;

    @(negedge clk);
    checkOutput("idle_cmd_ready", {31'b0, cmdReady}, 32'd1);
    cmdValid = 1'b1;
    cmdWrite = write;
    cmdAddr  = addr;
    cmdWdata = wdata;

    @(negedge clk);
    cmdValid = 1'b0;
    cmdWrite = ~write;
    cmdAddr  = $urandom;
    cmdWdata = $urandom;
    checkOutput("setup_psel",    {31'b0, psel},    32'd1);
    checkOutput("setup_penable", {31'b0, penable}, 32'd0);
    checkOutput("setup_paddr",   paddr,  addr);
    checkOutput("setup_pwdata",  pwdata, wdata);
    checkOutput("setup_pwrite",  {31'b0, pwrite},  {31'b0, write});
    checkOutput("setup_cmd_ready", {31'b0, cmdReady}, 32'd0);

    k = 0;
    @(negedge clk);
    while (psel && penable && k < 64) begin
      checkOutput("access_paddr",  paddr,  addr);
      checkOutput("access_pwdata", pwdata, wdata);
      pready  = (k == waits);
      pslverr = (k == waits) ? slverr : 1'b1;
      prdata  = (k == waits) ? rdVal : $urandom;
      k++;
      @(negedge clk);
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    checkOutput("access_cycles", k, expAccess);
    checkOutput("resp_valid",   {31'b0, rspValid},   32'd1);
    checkOutput("resp_psel",    {31'b0, psel},       32'd0);
    checkOutput("resp_rdata",   rspRdata, expRdata);
    checkOutput("resp_err",     {31'b0, rspErr},     {31'b0, expErr});
    checkOutput("resp_timeout", {31'b0, rspTimeout}, {31'b0, expTimeout});

    // A competing command while the response waits must be ignored.
    cmdValid = 1'b1;
    cmdAddr  = addr ^ 32'hFFFF_0000;
    repeat (rspDelay) begin
      @(negedge clk);
      checkOutput("hold_valid",     {31'b0, rspValid},   32'd1);
      checkOutput("hold_rdata",     rspRdata, expRdata);
      checkOutput("hold_err",       {31'b0, rspErr},     {31'b0, expErr});
      checkOutput("hold_timeout",   {31'b0, rspTimeout}, {31'b0, expTimeout});
      checkOutput("hold_cmd_ready", {31'b0, cmdReady},   32'd0);
    end
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    cmdValid = 1'b0;
    checkOutput("post_rsp_valid", {31'b0, rspValid}, 32'd0);
    checkOutput("post_cmd_ready", {31'b0, cmdReady}, 32'd1);
    checkOutput("post_psel",      {31'b0, psel},     32'd0);
    checkOutput("post_paddr_held", paddr, addr);
  endtask

  // Reset lands in the middle of an ACCESS wait state.
  task automatic applyResetMidAccess();
    @(negedge clk);
    cmdValid = 1'b1;
    cmdWrite = 1'b0;
    cmdAddr  = 32'h0000_0020;
    cmdWdata = 32'h0;
    @(negedge clk);
    cmdValid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_penable", {31'b0, penable}, 32'd1);
    preset = 1'b1;
    #1;
    checkOutput("reset_psel",      {31'b0, psel},      32'd0);
    checkOutput("reset_penable",   {31'b0, penable},   32'd0);
    checkOutput("reset_rsp_valid", {31'b0, rspValid},  32'd0);
    checkOutput("reset_paddr",     paddr, 32'h0);
    @(negedge clk);
    preset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("after_reset_cmd_ready", {31'b0, cmdReady}, 32'd1);
      checkOutput("after_reset_rsp_valid", {31'b0, rspValid}, 32'd0);
      checkOutput("after_reset_psel",      {31'b0, psel},     32'd0);
    end
  endtask

  // Main sequence: reset, directed cases, randomized transfers, summary.
  initial begin
    preset   = 1'b1;
    cmdValid = 1'b0;
    cmdWrite = 1'b0;
    cmdAddr  = 32'h0;
    cmdWdata = 32'h0;
    rspReady = 1'b0;
    prdata   = 32'h0;
    pready   = 1'b0;
    pslverr  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", {31'b0, cmdReady},   32'd1);
    checkOutput("rst_rsp_valid", {31'b0, rspValid},   32'd0);
    checkOutput("rst_psel",      {31'b0, psel},       32'd0);
    checkOutput("rst_penable",   {31'b0, penable},    32'd0);
    checkOutput("rst_paddr",     paddr,  32'h0);
    checkOutput("rst_pwdata",    pwdata, 32'h0);
    checkOutput("rst_rdata",     rspRdata, 32'h0);
    checkOutput("rst_err",       {31'b0, rspErr},     32'd0);
    checkOutput("rst_timeout",   {31'b0, rspTimeout}, 32'd0);
    preset = 1'b0;

    applyStimulus(1'b1, 32'h10, 32'hA5,        0,   1'b0, 32'h1234_5678, 0);
    applyStimulus(1'b0, 32'h08, 32'h0,         3,   1'b0, 32'hDEAD_BEEF, 0);
    applyStimulus(1'b1, 32'h0C, 32'h5A,        2,   1'b1, 32'hFFFF_FFFF, 1);
    applyStimulus(1'b0, 32'h04, 32'h0,         100, 1'b0, 32'hCAFE_F00D, 0);
    applyStimulus(1'b0, 32'h04, 32'h0,         3,   1'b0, 32'hCAFE_F00D, 0);
    applyStimulus(1'b0, 32'h14, 32'h0,         1,   1'b1, 32'h0BAD_0BAD, 5);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)),
                    1'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    applyResetMidAccess();
    applyStimulus(1'b0, 32'h18, 32'h0, 0, 1'b0, 32'h0000_00C3, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
